// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port arbiter for the memory valid/ready handshake; define MEM_ARB_TIMEOUT_EN for a BUSY timeout abort
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req_valid,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_req_ready,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  input  logic              m1_req_valid,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_req_ready,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_row,
  output logic              mem_req_valid,
  output logic [DATA_W-1:0] mem_data_write,
  input  logic [DATA_W-1:0] mem_data_read,
  input  logic              mem_ready,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
  state_t state, state_nx;
  logic rr_ptr, owner, grant, done, abort;
  logic [DATA_W-1:0] rsp_data;
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("TIMEOUT must be at least 2");
  end
  always_comb begin
    state_nx = state;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:
        if (mem_ready) state_nx = FLUSH;
        else if (m0_req_valid || m1_req_valid) begin
          m1_req_ready = m1_req_valid && (!m0_req_valid || rr_ptr);
          m0_req_ready = !m1_req_ready;
          state_nx = BUSY;
        end
      BUSY: begin
        mem_req_valid = 1'b1;
        done = mem_ready || abort;
        state_nx = done ? IDLE : BUSY;
      end
      FLUSH: begin
        mem_req_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign grant = m0_req_ready || m1_req_ready;
  assign rsp_data = (abort || mem_req_row) ? '0 : mem_data_read;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rr_ptr <= 1'b0;
      owner <= 1'b0;
      mem_req_addr <= '0;
      mem_req_row <= 1'b0;
      mem_data_write <= '0;
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
      m0_rsp_rdata <= '0;
      m1_rsp_rdata <= '0;
    end else begin
      m0_rsp_valid <= done && !owner;
      m1_rsp_valid <= done && owner;
      if (done && !owner) m0_rsp_rdata <= rsp_data;
      if (done && owner) m1_rsp_rdata <= rsp_data;
      if (grant) begin
        mem_req_addr <= m1_req_ready ? m1_req_addr : m0_req_addr;
        mem_req_row <= m1_req_ready ? m1_req_we : m0_req_we;
        mem_data_write <= m1_req_ready ? m1_req_wdata : m0_req_wdata;
        owner <= m1_req_ready;
        rr_ptr <= !m1_req_ready;
      end else if (state == IDLE && mem_ready)
        mem_req_row <= 1'b0;
    end
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1) > 4 ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] cnt;
  assign abort = state == BUSY && !mem_ready && cnt == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state == BUSY && !done) ? cnt + 1'b1 : '0;
      timeout_err <= timeout_err || abort;
    end
`else
  assign abort = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
